// File: rtl/controle_sessao_if.sv
// Request/response handshake bundle for controle_sessao.
// master drives requests, slave answers them.
interface controle_sessao_if;
  logic       req_valid;
  logic [2:0] req_func;
  logic       req_ready;
  logic       resp_valid;
  logic       resp_grant;

  modport master (
    output req_valid,
    output req_func,
    input  req_ready,
    input  resp_valid,
    input  resp_grant
  );

  modport slave (
    input  req_valid,
    input  req_func,
    output req_ready,
    output resp_valid,
    output resp_grant
  );
endinterface

// File: rtl/controle_sessao.sv
// Session controller: login, permission check, execution, timeout.
// Optional lockout on repeated denials enabled by DENY_LOCK_EN.
module controle_sessao #(
  parameter int EXEC_CYCLES = 4,
  parameter int TIMEOUT     = 16,
  parameter int MAX_DENY    = 3,
  parameter int LOCK_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             login,
  input  logic [2:0]       profile,
  input  logic             logout,
  controle_sessao_if.slave bus,
  output logic [2:0]       active_func,
  output logic             busy,
  output logic             session_active,
  output logic [2:0]       profile_disp,
  output logic             login_err,
  output logic             locked,
  output logic [CNT_W-1:0] deny_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READY  = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  localparam logic [2:0] P_ADM    = 3'b101;
  localparam logic [2:0] P_TESTER = 3'b011;
  localparam logic [2:0] P_USER   = 3'b001;
  localparam logic [2:0] P_GUEST  = 3'b110;

  localparam logic [CNT_W:0] EXEC_LIM = (CNT_W+1)'(EXEC_CYCLES);
  localparam logic [CNT_W:0] TOUT_LIM = (CNT_W+1)'(TIMEOUT);
  localparam logic [CNT_W:0] LOCK_LIM = (CNT_W+1)'(LOCK_CYCLES);
  localparam logic [CNT_W:0] DENY_LIM = (CNT_W+1)'(MAX_DENY);

  logic [1:0]       state_q, state_d;
  logic [2:0]       prof_q, prof_d;
  logic [2:0]       func_q, func_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] deny_q, deny_d;
  logic             rv_q, rv_d;
  logic             rg_q, rg_d;
  logic             err_q, err_d;

  logic [CNT_W:0]   idle_nx;
  logic [CNT_W:0]   cyc_nx;
  logic [CNT_W-1:0] deny_inc;
  logic             grant;

  function automatic logic valid_prof(input logic [2:0] p);
    logic v;
    v = 1'b0;
    unique case (1'b1)
      (p == P_ADM),
      (p == P_TESTER),
      (p == P_USER),
      (p == P_GUEST): v = 1'b1;
      default:        v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic perm(input logic [2:0] p,
                                input logic [2:0] f);
    logic adm, tst, usr, gst, g;
    adm = (p == P_ADM);
    tst = (p == P_TESTER);
    usr = (p == P_USER);
    gst = (p == P_GUEST);
    case (f)
      3'd1, 3'd6: g = adm | tst | usr | gst;
      3'd2:       g = adm | tst;
      3'd3, 3'd4: g = adm | tst | usr;
      3'd5, 3'd7: g = adm;
      default:    g = 1'b0;
    endcase
    return g;
  endfunction

  assign idle_nx  = {1'b0, idle_q} + 1'b1;
  assign cyc_nx   = {1'b0, cyc_q} + 1'b1;
  assign deny_inc = (&deny_q) ? deny_q : deny_q + 1'b1;
  assign grant    = perm(prof_q, bus.req_func);

  // next-state and counter update for the session FSM
  always_comb begin
    state_d = state_q;
    prof_d  = prof_q;
    func_d  = func_q;
    idle_d  = idle_q;
    cyc_d   = cyc_q;
    deny_d  = deny_q;
    rv_d    = 1'b0;
    rg_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (login) begin
          if (valid_prof(profile)) begin
            state_d = S_READY;
            prof_d  = profile;
            idle_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_READY: begin
        if (logout) begin
          state_d = S_IDLE;
          prof_d  = '0;
          deny_d  = '0;
          idle_d  = '0;
        end else if (bus.req_valid) begin
          rv_d   = 1'b1;
          rg_d   = grant;
          idle_d = '0;
          if (grant) begin
            state_d = S_EXEC;
            func_d  = bus.req_func;
            cyc_d   = '0;
            deny_d  = '0;
          end else begin
            deny_d = deny_inc;
`ifdef DENY_LOCK_EN
            if ({1'b0, deny_inc} >= DENY_LIM) begin
              state_d = S_LOCKED;
              prof_d  = '0;
              cyc_d   = '0;
            end
`endif
          end
        end else if (idle_nx >= TOUT_LIM) begin
          state_d = S_IDLE;
          prof_d  = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_nx[CNT_W-1:0];
        end
      end
      S_EXEC: begin
        if (logout) begin
          state_d = S_IDLE;
          prof_d  = '0;
          func_d  = '0;
          deny_d  = '0;
          cyc_d   = '0;
        end else if (cyc_nx >= EXEC_LIM) begin
          state_d = S_READY;
          func_d  = '0;
          idle_d  = '0;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_nx[CNT_W-1:0];
        end
      end
      S_LOCKED: begin
        if (cyc_nx >= LOCK_LIM) begin
          state_d = S_IDLE;
          deny_d  = '0;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_nx[CNT_W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      prof_q  <= '0;
      func_q  <= '0;
      idle_q  <= '0;
      cyc_q   <= '0;
      deny_q  <= '0;
      rv_q    <= 1'b0;
      rg_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prof_q  <= prof_d;
      func_q  <= func_d;
      idle_q  <= idle_d;
      cyc_q   <= cyc_d;
      deny_q  <= deny_d;
      rv_q    <= rv_d;
      rg_q    <= rg_d;
      err_q   <= err_d;
    end
  end

  // profile code to display code
  always_comb begin
    unique case (1'b1)
      (prof_q == P_ADM):    profile_disp = 3'b101;
      (prof_q == P_TESTER): profile_disp = 3'b110;
      (prof_q == P_USER):   profile_disp = 3'b100;
      (prof_q == P_GUEST):  profile_disp = 3'b011;
      default:              profile_disp = 3'b000;
    endcase
  end

  assign bus.req_ready  = (state_q == S_READY) && !logout;
  assign bus.resp_valid = rv_q;
  assign bus.resp_grant = rv_q & rg_q;

  assign active_func    = (state_q == S_EXEC) ? func_q : 3'd0;
  assign busy           = (state_q == S_EXEC);
  assign session_active = (state_q == S_READY) ||
                          (state_q == S_EXEC);
  assign login_err      = err_q;
  assign deny_count     = deny_q;
`ifdef DENY_LOCK_EN
  assign locked         = (state_q == S_LOCKED);
`else
  assign locked         = 1'b0;
`endif

endmodule

// File: doc/controle_sessao.md
Name: controle_sessao

Overview:
- Sequential session controller for the profile/function permission datapath.
- Accepts a login with a 3-bit profile code and latches it for the session.
- Accepts 3-bit function requests via a valid/ready handshake, checks them against the fixed permission matrix, and runs granted functions for a fixed number of cycles.
- Enforces idle timeout, logout and a lockout after repeated denials; feeds the display/status path.

Parameters:
- EXEC_CYCLES, 4, cycles busy stays high per granted function (>=1)
- TIMEOUT, 16, consecutive READY cycles with no accepted request before auto-logout (>=2)
- MAX_DENY, 3, consecutive denials that trigger lockout (>=1)
- LOCK_CYCLES, 8, cycles spent in LOCKED (>=1)
- CNT_W, 8, width of internal cycle counters; every other parameter must be < 2^CNT_W

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- login  in  1  login strobe, sampled only in IDLE
- profile  in  3  profile code {A,B,C}: 101 ADM, 011 TESTER, 001 USER, 110 GUEST, 000 AUTO; 010/100/111 invalid
- logout  in  1  logout strobe
- req_valid  in  1  function request valid
- req_func  in  3  function code {D,E,F}: 1..7 = FUN01..FUN07, 0 = none
- req_ready  out  1  combinational: state==READY && !logout
- resp_valid  out  1  one-cycle registered pulse, the cycle after request acceptance
- resp_grant  out  1  grant(1)/deny(0); meaningful only while resp_valid=1, else 0
- active_func  out  3  function being executed, 0 when not in EXEC
- busy  out  1  high exactly while in EXEC
- session_active  out  1  high in READY and EXEC
- profile_disp  out  3  display code of latched profile: ADM 101, TESTER 110, USER 100, GUEST 011; 000 when no session
- login_err  out  1  one-cycle pulse on a rejected login
- locked  out  1  high in LOCKED
- deny_count  out  CNT_W  consecutive-denial counter

Behaviour:
- Reset (async assert, synchronous release): state IDLE; all outputs 0; latched profile and all counters cleared.
- Permission matrix:
  - FUN01, FUN06: ADM, TESTER, USER, GUEST
  - FUN02: ADM, TESTER
  - FUN03, FUN04: ADM, TESTER, USER
  - FUN05, FUN07: ADM only
  - func 0: always denied
- IDLE:
  - login with ADM/TESTER/USER/GUEST: latch profile; READY next cycle; idle counter = 0.
  - login with AUTO or an invalid code: stay IDLE; login_err=1 for the next cycle.
  - logout and req_valid ignored.
- READY:
  - Handshake completes when req_valid && req_ready. resp_valid=1 on the next cycle, with resp_grant from the matrix.
  - Grant: enter EXEC on the same edge; active_func=req_func; deny_count=0.
  - Deny: stay READY; deny_count+1.
  - Lockout: the deny that brings deny_count to MAX_DENY moves to LOCKED instead of READY (see macro).
  - Idle counter: +1 on every READY cycle with no accepted request; reset on acceptance. When the count reaches TIMEOUT, go to IDLE and clear the profile; deny_count is kept.
  - logout: go to IDLE next cycle; profile and deny_count cleared; takes priority over a same-cycle req_valid (req_ready=0, so the request is not accepted).
- EXEC:
  - busy=1 for exactly EXEC_CYCLES cycles, then READY with idle counter = 0.
  - req_ready=0; requests are not accepted or queued.
  - logout aborts: IDLE next cycle; active_func=0; busy=0; session cleared.
- LOCKED:
  - login, logout and req_valid ignored; profile cleared on entry.
  - After LOCK_CYCLES cycles: go to IDLE; deny_count=0.
- login outside IDLE is ignored.
- Counters saturate; they never wrap.
- Reset asserted in any state returns immediately to the reset values.

Optional Feature:
- Macro: DENY_LOCK_EN
- Defined: lockout behaves as described; LOCKED is reachable.
- Undefined: LOCKED is never entered; locked tied 0; deny_count still counts, saturating at 2^CNT_W-1, and clears on a grant or logout.

Test Plan:
- Reset mid-EXEC: assert rst_n=0 during busy -> all outputs 0 immediately; IDLE after release.
- login profile=101 (ADM), then request func=7 -> resp_valid with resp_grant=1; active_func=7; busy high exactly 4 cycles; profile_disp=101 throughout.
- login profile=110 (GUEST), then requests func=2, 5, 0 (DENY_LOCK_EN defined) -> three responses with resp_grant=0; deny_count reaches 3; locked=1 for 8 cycles; then IDLE with deny_count=0.
- login profile=000, then login profile=111 -> login_err pulse each time; session_active stays 0.
- login profile=001 (USER), no requests -> session_active drops after 16 READY cycles; profile_disp=000.
- USER session: logout and req_valid (func=3) in the same cycle -> req_ready=0; no resp_valid; IDLE next cycle. Separately, logout during EXEC -> busy and active_func clear the next cycle.
